// File: rtl/sram_client_arbiter.sv
// SRAM access arbiter: picks one owner among NUM_CLIENTS requesters, muxes its
// address/write data/we_n onto the SRAM_Controller port, and routes read-valid
// strobes back to the client that issued each read.
module sram_client_arbiter #(
    parameter int unsigned NUM_CLIENTS  = 4,
    parameter int unsigned ROUND_ROBIN  = 1,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_HOLD     = 0
) (
    input  logic                      Clock_50,
    input  logic                      Reset,
    input  logic [NUM_CLIENTS-1:0]    Client_req,
    input  logic [NUM_CLIENTS-1:0]    Client_lock,
    input  logic [NUM_CLIENTS*18-1:0] Client_address,
    input  logic [NUM_CLIENTS*16-1:0] Client_write_data,
    input  logic [NUM_CLIENTS-1:0]    Client_we_n,
    output logic [NUM_CLIENTS-1:0]    Client_grant,
    output logic [NUM_CLIENTS-1:0]    Client_read_valid,
    output logic [15:0]               Client_read_data,
    output logic [2:0]                Owner_id,
    output logic [17:0]               SRAM_address,
    output logic [15:0]               SRAM_write_data,
    output logic                      SRAM_we_n,
    input  logic [15:0]               SRAM_read_data
);

    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {
        S_ARB_IDLE,
        S_ARB_OWN,
        S_ARB_HANDOVER
    } arb_state_e;

    arb_state_e             state_q, state_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [2:0]             owner_q, owner_d;
    logic [2:0]             last_q, last_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [NUM_CLIENTS-1:0] rv_q [READ_LATENCY];

    logic [2*NUM_CLIENTS-1:0] req_rot;
    int unsigned              scan_start;
    int unsigned              win_idx;
    logic                     win_found;
    logic [2:0]               winner;
    logic                     owner_req, owner_lock, others_req, preempt;
    logic [NUM_CLIENTS-1:0]   read_push;

    // Owner status is derived from the one-hot grant to avoid variable indexing.
    assign owner_req  = |(Client_req & grant_q);
    assign owner_lock = |(Client_lock & grant_q);
    assign others_req = |(Client_req & ~grant_q);
    assign preempt    = (MAX_HOLD > 0) && (hold_q == HOLD_LAST) && !owner_lock && others_req;
    // A granted cycle with we_n high is a read issued by the owner.
    assign read_push  = grant_q & Client_we_n;

    // Winner search: rotate the request vector so the scan starts at the favoured index.
    always_comb begin
        scan_start = (ROUND_ROBIN != 0) ? ((32'(last_q) + 1) % NUM_CLIENTS) : 0;
        req_rot    = {Client_req, Client_req} >> scan_start;
        win_idx    = 0;
        win_found  = 1'b0;
        for (int j = 0; j < NUM_CLIENTS; j++) begin
            if (!win_found && req_rot[j]) begin
                win_found = 1'b1;
                win_idx   = (scan_start + j) % NUM_CLIENTS;
            end
        end
        winner = 3'(win_idx);
    end

    // Next-state logic for the ownership FSM, grant and hold counter.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_ARB_IDLE: begin
                if (|Client_req) begin
                    grant_d = NUM_CLIENTS'(1) << winner;
                    owner_d = winner;
                    last_d  = winner;
                    hold_d  = '0;
                    state_d = S_ARB_OWN;
                end
            end
            S_ARB_OWN: begin
                // Saturate so a late competitor or lock release preempts at once.
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
                if ((!owner_req && !owner_lock) || preempt) begin
                    grant_d = '0;
                    state_d = S_ARB_HANDOVER;
                end
            end
            S_ARB_HANDOVER: begin
                state_d = S_ARB_IDLE;
            end
            default: begin
                state_d = S_ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q <= S_ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= 3'(NUM_CLIENTS - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Read-valid pipeline: tags each read with its issuer, matched to SRAM latency.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rv_q[i] <= '0;
            end
        end else begin
            rv_q[0] <= read_push;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rv_q[i] <= rv_q[i-1];
            end
        end
    end

    // SRAM port mux driven from the registered grant; idle port is a harmless read of 0.
    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_q[i]) begin
                SRAM_address    = Client_address[18*i +: 18];
                SRAM_write_data = Client_write_data[16*i +: 16];
                SRAM_we_n       = Client_we_n[i];
            end
        end
    end

    assign Client_grant      = grant_q;
    assign Owner_id          = owner_q;
    assign Client_read_valid = rv_q[READ_LATENCY-1];
    assign Client_read_data  = SRAM_read_data;

endmodule

// File: tb/tb_sram_client_arbiter.sv
// Self-checking bench for sram_client_arbiter: three instances cover round-robin,
// fixed priority and max-hold preemption; all share one stimulus bus.
module tb_sram_client_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [3:0]  we_n;
    logic [71:0] addr_flat;
    logic [63:0] wdata_flat;

    logic [3:0]  a_grant, a_rv, b_grant, b_rv, c_grant, c_rv;
    logic [15:0] a_rdata, b_rdata, c_rdata;
    logic [2:0]  a_owner, b_owner, c_owner;
    logic [17:0] a_saddr, b_saddr, c_saddr;
    logic [15:0] a_swd, b_swd, c_swd;
    logic        a_swe, b_swe, c_swe;
    logic [15:0] a_sram_rd;
    logic [15:0] zero16;
    logic [17:0] sram_a1, sram_a2;

    int checks;
    int errors;

    sram_client_arbiter #(.NUM_CLIENTS(4), .ROUND_ROBIN(1), .READ_LATENCY(2), .MAX_HOLD(0)) dut_rr (
        .Clock_50(clk), .Reset(rst), .Client_req(req), .Client_lock(lock),
        .Client_address(addr_flat), .Client_write_data(wdata_flat), .Client_we_n(we_n),
        .Client_grant(a_grant), .Client_read_valid(a_rv), .Client_read_data(a_rdata),
        .Owner_id(a_owner), .SRAM_address(a_saddr), .SRAM_write_data(a_swd),
        .SRAM_we_n(a_swe), .SRAM_read_data(a_sram_rd)
    );

    sram_client_arbiter #(.NUM_CLIENTS(4), .ROUND_ROBIN(0), .READ_LATENCY(2), .MAX_HOLD(0)) dut_fp (
        .Clock_50(clk), .Reset(rst), .Client_req(req), .Client_lock(lock),
        .Client_address(addr_flat), .Client_write_data(wdata_flat), .Client_we_n(we_n),
        .Client_grant(b_grant), .Client_read_valid(b_rv), .Client_read_data(b_rdata),
        .Owner_id(b_owner), .SRAM_address(b_saddr), .SRAM_write_data(b_swd),
        .SRAM_we_n(b_swe), .SRAM_read_data(zero16)
    );

    sram_client_arbiter #(.NUM_CLIENTS(4), .ROUND_ROBIN(1), .READ_LATENCY(2), .MAX_HOLD(8)) dut_ph (
        .Clock_50(clk), .Reset(rst), .Client_req(req), .Client_lock(lock),
        .Client_address(addr_flat), .Client_write_data(wdata_flat), .Client_we_n(we_n),
        .Client_grant(c_grant), .Client_read_valid(c_rv), .Client_read_data(c_rdata),
        .Owner_id(c_owner), .SRAM_address(c_saddr), .SRAM_write_data(c_swd),
        .SRAM_we_n(c_swe), .SRAM_read_data(zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: returns the low 16 address bits two cycles after issue.
    always @(posedge clk) begin
        sram_a1 <= a_saddr;
        sram_a2 <= sram_a1;
    end
    assign a_sram_rd = sram_a2[15:0];
    assign zero16    = 16'h0000;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we_n;
        logic [15:0] addr;
        logic [3:0]  grant;
        logic [2:0]  owner;
        logic [17:0] saddr;
        logic        swe;
        logic [3:0]  rv;
        logic        dchk;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Client i sees address {i, a} and write data {0, i, a[11:0]}.
    task automatic set_addr(input logic [15:0] a);
        for (int i = 0; i < 4; i++) begin
            addr_flat[18*i +: 18]  = {2'(i), a};
            wdata_flat[16*i +: 16] = {1'b0, 3'(i), a[11:0]};
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        lock = 4'b0000;
        we_n = 4'b1111;
        set_addr(16'h0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int k;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = '0;
        lock   = '0;
        we_n   = '1;
        set_addr(16'h0000);

        //            req      we_n     addr      grant    own   saddr        swe   rv       dchk  data
        vecs[0]  = '{4'b0000, 4'b1111, 16'h0000, 4'b0000, 3'd0, 18'h00000, 1'b1, 4'b0000, 1'b0, 16'h0000};
        vecs[1]  = '{4'b0100, 4'b1111, 16'h0005, 4'b0000, 3'd0, 18'h00000, 1'b1, 4'b0000, 1'b0, 16'h0000};
        vecs[2]  = '{4'b0100, 4'b1111, 16'h0006, 4'b0100, 3'd2, 18'h20006, 1'b1, 4'b0000, 1'b0, 16'h0000};
        vecs[3]  = '{4'b0100, 4'b1011, 16'h0007, 4'b0100, 3'd2, 18'h20007, 1'b0, 4'b0000, 1'b0, 16'h0000};
        vecs[4]  = '{4'b0000, 4'b1111, 16'h0008, 4'b0100, 3'd2, 18'h20008, 1'b1, 4'b0100, 1'b0, 16'h0000};
        vecs[5]  = '{4'b0000, 4'b1111, 16'h0009, 4'b0000, 3'd0, 18'h00000, 1'b1, 4'b0000, 1'b0, 16'h0000};
        vecs[6]  = '{4'b0000, 4'b1111, 16'h000a, 4'b0000, 3'd0, 18'h00000, 1'b1, 4'b0100, 1'b0, 16'h0000};
        vecs[7]  = '{4'b0000, 4'b1111, 16'h000b, 4'b0000, 3'd0, 18'h00000, 1'b1, 4'b0000, 1'b0, 16'h0000};
        vecs[8]  = '{4'b0010, 4'b1111, 16'h0000, 4'b0000, 3'd0, 18'h00000, 1'b1, 4'b0000, 1'b0, 16'h0000};
        vecs[9]  = '{4'b0010, 4'b1111, 16'h0010, 4'b0010, 3'd1, 18'h10010, 1'b1, 4'b0000, 1'b0, 16'h0000};
        vecs[10] = '{4'b0010, 4'b1111, 16'h0011, 4'b0010, 3'd1, 18'h10011, 1'b1, 4'b0000, 1'b0, 16'h0000};
        vecs[11] = '{4'b0010, 4'b1111, 16'h0012, 4'b0010, 3'd1, 18'h10012, 1'b1, 4'b0010, 1'b1, 16'h0010};
        vecs[12] = '{4'b0010, 4'b1111, 16'h0013, 4'b0010, 3'd1, 18'h10013, 1'b1, 4'b0010, 1'b1, 16'h0011};
        vecs[13] = '{4'b0000, 4'b0000, 16'h0014, 4'b0010, 3'd1, 18'h10014, 1'b0, 4'b0010, 1'b1, 16'h0012};
        vecs[14] = '{4'b0000, 4'b1111, 16'h0015, 4'b0000, 3'd0, 18'h00000, 1'b1, 4'b0010, 1'b1, 16'h0013};
        vecs[15] = '{4'b0000, 4'b1111, 16'h0016, 4'b0000, 3'd0, 18'h00000, 1'b1, 4'b0000, 1'b0, 16'h0000};

        // Single request, datapath, read latency and reads returning across handover.
        do_reset();
        for (int r = 0; r < 16; r++) begin
            req  = vecs[r].req;
            we_n = vecs[r].we_n;
            set_addr(vecs[r].addr);
            @(negedge clk);
            check($sformatf("vec%0d_grant", r), 32'(a_grant), 32'(vecs[r].grant));
            check($sformatf("vec%0d_saddr", r), 32'(a_saddr), 32'(vecs[r].saddr));
            check($sformatf("vec%0d_we_n", r), 32'(a_swe), 32'(vecs[r].swe));
            check($sformatf("vec%0d_rvalid", r), 32'(a_rv), 32'(vecs[r].rv));
            if (vecs[r].grant != 4'b0000) begin
                check($sformatf("vec%0d_owner", r), 32'(a_owner), 32'(vecs[r].owner));
                check($sformatf("vec%0d_wdata", r), 32'(a_swd),
                      32'({1'b0, vecs[r].owner, vecs[r].addr[11:0]}));
            end else begin
                check($sformatf("vec%0d_wdata", r), 32'(a_swd), 32'h0);
            end
            if (vecs[r].dchk) begin
                check($sformatf("vec%0d_rdata", r), 32'(a_rdata), 32'(vecs[r].data));
            end
            next_cycle();
        end

        // Round-robin rotation with one handover dead cycle plus one idle cycle.
        do_reset();
        req  = 4'b1111;
        we_n = 4'b0000;
        set_addr(16'h0055);
        @(negedge clk);
        check("rr_first_idle", 32'(a_grant), 32'h0);
        next_cycle();
        for (int n = 0; n < 5; n++) begin
            k = n % 4;
            for (int h = 0; h < 4; h++) begin
                if (h == 3) req[k] = 1'b0;
                @(negedge clk);
                check($sformatf("rr%0d_grant", n), 32'(a_grant), 32'(4'b0001 << k));
                check($sformatf("rr%0d_owner", n), 32'(a_owner), k);
                next_cycle();
            end
            req[k] = 1'b1;
            @(negedge clk);
            check($sformatf("rr%0d_handover_grant", n), 32'(a_grant), 32'h0);
            check($sformatf("rr%0d_handover_we_n", n), 32'(a_swe), 32'h1);
            check($sformatf("rr%0d_handover_addr", n), 32'(a_saddr), 32'h0);
            next_cycle();
            @(negedge clk);
            check($sformatf("rr%0d_idle_grant", n), 32'(a_grant), 32'h0);
            next_cycle();
        end

        // Fixed priority: client 1 is regranted ahead of client 3.
        do_reset();
        req = 4'b1010;
        @(negedge clk); check("fp_idle", 32'(b_grant), 32'h0); next_cycle();
        @(negedge clk); check("fp_first", 32'(b_grant), 32'b0010); next_cycle();
        req = 4'b1000;
        @(negedge clk); check("fp_release_cycle", 32'(b_grant), 32'b0010); next_cycle();
        req = 4'b1010;
        @(negedge clk); check("fp_handover", 32'(b_grant), 32'h0); next_cycle();
        @(negedge clk); check("fp_idle2", 32'(b_grant), 32'h0); next_cycle();
        @(negedge clk); check("fp_regrant1", 32'(b_grant), 32'b0010); next_cycle();
        req = 4'b1000;
        @(negedge clk); check("fp_release2", 32'(b_grant), 32'b0010); next_cycle();
        @(negedge clk); check("fp_handover2", 32'(b_grant), 32'h0); next_cycle();
        @(negedge clk); check("fp_idle3", 32'(b_grant), 32'h0); next_cycle();
        @(negedge clk);
        check("fp_grant3", 32'(b_grant), 32'b1000);
        check("fp_owner3", 32'(b_owner), 32'd3);
        next_cycle();

        // Preemption after 8 owned cycles.
        do_reset();
        req = 4'b0001;
        @(negedge clk); check("ph_idle", 32'(c_grant), 32'h0); next_cycle();
        for (int h = 0; h < 8; h++) begin
            if (h == 1) req = 4'b0101;
            @(negedge clk);
            check($sformatf("ph_hold%0d", h), 32'(c_grant), 32'b0001);
            next_cycle();
        end
        @(negedge clk); check("ph_preempt_handover", 32'(c_grant), 32'h0); next_cycle();
        @(negedge clk); check("ph_preempt_idle", 32'(c_grant), 32'h0); next_cycle();
        @(negedge clk);
        check("ph_grant2", 32'(c_grant), 32'b0100);
        check("ph_owner2", 32'(c_owner), 32'd2);
        next_cycle();

        // Lock suppresses preemption; releasing it with a saturated counter preempts at once.
        do_reset();
        req  = 4'b0001;
        lock = 4'b0001;
        @(negedge clk); check("lk_idle", 32'(c_grant), 32'h0); next_cycle();
        for (int h = 0; h < 20; h++) begin
            if (h == 1) req = 4'b0101;
            @(negedge clk);
            check($sformatf("lk_hold%0d", h), 32'(c_grant), 32'b0001);
            next_cycle();
        end
        lock = 4'b0000;
        @(negedge clk); check("lk_unlock_cycle", 32'(c_grant), 32'b0001); next_cycle();
        @(negedge clk); check("lk_preempt", 32'(c_grant), 32'h0); next_cycle();

        // Reset with two reads in flight: no read-valid may escape.
        do_reset();
        req  = 4'b0010;
        we_n = 4'b1111;
        set_addr(16'h0030);
        @(negedge clk); check("mr_idle", 32'(a_grant), 32'h0); next_cycle();
        @(negedge clk); check("mr_read0", 32'(a_grant), 32'b0010); next_cycle();
        rst = 1'b1;
        @(negedge clk); check("mr_read1", 32'(a_grant), 32'b0010); next_cycle();
        rst = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        check("mr_grant", 32'(a_grant), 32'h0);
        check("mr_owner", 32'(a_owner), 32'h0);
        check("mr_saddr", 32'(a_saddr), 32'h0);
        check("mr_we_n", 32'(a_swe), 32'h1);
        next_cycle();
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            check($sformatf("mr_no_rvalid%0d", h), 32'(a_rv), 32'h0);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
